// File: rtl/sram_like_pkg.sv
// Shared constants and width helpers for the sram-like request arbiter.
// ARB_RR_EN (defined at build time) selects round-robin instead of fixed priority.
package sram_like_pkg;

  // Access size encoding carried on ch_size / mem_size.
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  function automatic int id_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Widths for the default configuration (NCH = 2, DEPTH = 4).
  localparam int ID_W  = id_width(2);
  localparam int CNT_W = cnt_width(4);

endpackage

// File: rtl/sram_like_arbiter_id_fifo.sv
// Circular FIFO of channel ids for outstanding requests; supports push and
// pop in the same cycle, pointers wrap modulo DEPTH.
module id_fifo
  import sram_like_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        push,
  input  logic [W-1:0]                push_id,
  input  logic                        pop,
  output logic [W-1:0]                head_id,
  output logic                        full,
  output logic                        empty,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_width(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head_id = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: storage holds no control state, so it is left out of reset; only
  // pointers and count need a known value.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_id;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// N-to-1 arbiter for sram-like split-handshake requests with in-order response
// routing. Define ARB_RR_EN for round-robin; otherwise channel 0 has priority.
module sram_like_arbiter
  import sram_like_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [NCH-1:0]              ch_req,
  input  logic [NCH-1:0]              ch_wr,
  input  logic [2*NCH-1:0]            ch_size,
  input  logic [(DW/8)*NCH-1:0]       ch_wstrb,
  input  logic [AW*NCH-1:0]           ch_addr,
  input  logic [DW*NCH-1:0]           ch_wdata,
  output logic [NCH-1:0]              ch_addr_ok,
  output logic [NCH-1:0]              ch_data_ok,
  output logic [DW-1:0]               ch_rdata,
  output logic                        mem_req,
  output logic                        mem_wr,
  output logic [1:0]                  mem_size,
  output logic [DW/8-1:0]             mem_wstrb,
  output logic [AW-1:0]               mem_addr,
  output logic [DW-1:0]               mem_wdata,
  input  logic                        mem_addr_ok,
  input  logic                        mem_data_ok,
  input  logic [DW-1:0]               mem_rdata,
  output logic [cnt_width(DEPTH)-1:0] pending_cnt,
  output logic                        err
);

  localparam int IDW = id_width(NCH);
  localparam int SW  = DW / 8;

  logic           lock_q;
  logic [IDW-1:0] lock_id_q;
  logic [IDW-1:0] arb_id;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] head_id;
  logic           fifo_full;
  logic           fifo_empty;
  logic           accept;
  logic           pop;

`ifdef ARB_RR_EN
  logic [IDW-1:0] rr_ptr_q;

  // Scan downward so the last hit is the first channel after the pointer.
  // NOTE: combinational outputs get a default first so no path infers a latch.
  always_comb begin
    arb_id = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ch_req[(int'(rr_ptr_q) + 1 + i) % NCH])
        arb_id = IDW'((int'(rr_ptr_q) + 1 + i) % NCH);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     rr_ptr_q <= IDW'(NCH - 1);
    else if (accept) rr_ptr_q <= grant_id;
  end
`else
  always_comb begin
    arb_id = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ch_req[i]) arb_id = IDW'(i);
    end
  end
`endif

  // A request left waiting keeps its channel until accepted.
  assign grant_id = lock_q ? lock_id_q : arb_id;

  assign mem_req   = resetn && (|ch_req) && !fifo_full;
  assign accept    = mem_req && mem_addr_ok;
  assign pop       = resetn && mem_data_ok && !fifo_empty;
  assign mem_wr    = ch_wr[grant_id];
  assign mem_size  = ch_size[int'(grant_id) * 2 +: 2];
  assign mem_wstrb = ch_wstrb[int'(grant_id) * SW +: SW];
  assign mem_addr  = ch_addr[int'(grant_id) * AW +: AW];
  assign mem_wdata = ch_wdata[int'(grant_id) * DW +: DW];
  assign ch_rdata  = mem_rdata;

  always_comb begin
    ch_addr_ok = '0;
    ch_data_ok = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_addr_ok[i] = accept && (grant_id == IDW'(i));
      ch_data_ok[i] = pop && (head_id == IDW'(i));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      err       <= 1'b0;
    end else begin
      if (accept) begin
        lock_q <= 1'b0;
      end else if (mem_req) begin
        lock_q    <= 1'b1;
        lock_id_q <= grant_id;
      end
      // A response with nothing outstanding is a downstream protocol breach.
      if (mem_data_ok && fifo_empty) err <= 1'b1;
    end
  end

  id_fifo #(
    .DEPTH (DEPTH),
    .W     (IDW)
  ) u_id_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (accept),
    .push_id (grant_id),
    .pop     (pop),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (pending_cnt)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed scenarios then random
// traffic, compared against a queue-based reference model.
module tb_sram_like_arbiter;
  import sram_like_pkg::*;

  localparam int NCH   = 2;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;

  logic                    clk = 1'b0;
  logic                    resetn;
  logic [NCH-1:0]          ch_req;
  logic [NCH-1:0]          ch_wr;
  logic [2*NCH-1:0]        ch_size;
  logic [SW*NCH-1:0]       ch_wstrb;
  logic [AW*NCH-1:0]       ch_addr;
  logic [DW*NCH-1:0]       ch_wdata;
  logic [NCH-1:0]          ch_addr_ok;
  logic [NCH-1:0]          ch_data_ok;
  logic [DW-1:0]           ch_rdata;
  logic                    mem_req;
  logic                    mem_wr;
  logic [1:0]              mem_size;
  logic [SW-1:0]           mem_wstrb;
  logic [AW-1:0]           mem_addr;
  logic [DW-1:0]           mem_wdata;
  logic                    mem_addr_ok;
  logic                    mem_data_ok;
  logic [DW-1:0]           mem_rdata;
  logic [CNT_W-1:0]        pending_cnt;
  logic                    err;

  sram_like_arbiter #(
    .NCH(NCH), .DEPTH(DEPTH), .AW(AW), .DW(DW)
  ) dut (
    .clk(clk), .resetn(resetn),
    .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size), .ch_wstrb(ch_wstrb),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok), .ch_rdata(ch_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .pending_cnt(pending_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-channel requester state (held stable until accepted).
  logic [NCH-1:0] req_r;
  logic           wr_r    [NCH];
  logic [1:0]     size_r  [NCH];
  logic [SW-1:0]  wstrb_r [NCH];
  logic [AW-1:0]  addr_r  [NCH];
  logic [DW-1:0]  wdata_r [NCH];

  // Reference model: outstanding ids in issue order, waiting grant, RR history.
  int q_ids[$];
  int locked;
  int last;
  bit m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_ids.delete();
    locked = -1;
    last   = NCH - 1;
    m_err  = 1'b0;
  endtask

  function automatic int model_grant();
    if (locked >= 0) return locked;
`ifdef ARB_RR_EN
    for (int k = 1; k <= NCH; k++)
      if (req_r[(last + k) % NCH]) return (last + k) % NCH;
`else
    for (int k = 0; k < NCH; k++)
      if (req_r[k]) return k;
`endif
    return 0;
  endfunction

  task automatic raise(input int c);
    if (!req_r[c]) begin
      req_r[c]   = 1'b1;
      wr_r[c]    = 1'($urandom % 2);
      size_r[c]  = 2'($urandom % 3);
      wstrb_r[c] = SW'($urandom);
      addr_r[c]  = AW'($urandom);
      wdata_r[c] = DW'($urandom);
    end
  endtask

  task automatic apply();
    ch_req = req_r;
    for (int c = 0; c < NCH; c++) begin
      ch_wr[c]               = wr_r[c];
      ch_size[c*2 +: 2]      = size_r[c];
      ch_wstrb[c*SW +: SW]   = wstrb_r[c];
      ch_addr[c*AW +: AW]    = addr_r[c];
      ch_wdata[c*DW +: DW]   = wdata_r[c];
    end
  endtask

  // One clock: drive, predict, check at the falling edge, advance the model.
  task automatic cycle();
    int             g;
    bit             ereq;
    bit             acc;
    logic [NCH-1:0] eaok;
    logic [NCH-1:0] edok;
    apply();
    ereq = (|req_r) && (q_ids.size() < DEPTH);
    g    = model_grant();
    acc  = ereq && mem_addr_ok;
    eaok = '0;
    edok = '0;
    if (acc) eaok[g] = 1'b1;
    if (mem_data_ok && q_ids.size() > 0) edok[q_ids[0]] = 1'b1;
    @(negedge clk);
    check("mem_req",     32'(mem_req),     32'(ereq));
    check("ch_addr_ok",  32'(ch_addr_ok),  32'(eaok));
    check("ch_data_ok",  32'(ch_data_ok),  32'(edok));
    check("ch_rdata",    ch_rdata,         mem_rdata);
    check("pending_cnt", 32'(pending_cnt), 32'(q_ids.size()));
    check("err",         32'(err),         32'(m_err));
    if (ereq) begin
      check("mem_addr",  mem_addr,         addr_r[g]);
      check("mem_wdata", mem_wdata,        wdata_r[g]);
      check("mem_wr",    32'(mem_wr),      32'(wr_r[g]));
      check("mem_size",  32'(mem_size),    32'(size_r[g]));
      check("mem_wstrb", 32'(mem_wstrb),   32'(wstrb_r[g]));
    end
    if (mem_data_ok) begin
      if (q_ids.size() > 0) void'(q_ids.pop_front());
      else m_err = 1'b1;
    end
    if (acc) begin
      q_ids.push_back(g);
      last     = g;
      locked   = -1;
      req_r[g] = 1'b0;
    end else if (ereq) begin
      locked = g;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn      = 1'b0;
    req_r       = '0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
    for (int c = 0; c < NCH; c++) begin
      wr_r[c] = 1'b0; size_r[c] = SIZE_W; wstrb_r[c] = '1; addr_r[c] = '0; wdata_r[c] = '0;
    end
    model_reset();

    // Reset state: requests present but everything quiet while held in reset.
    raise(0); raise(1); mem_addr_ok = 1'b1; apply();
    #3;
    check("rst_mem_req",     32'(mem_req),     32'(0));
    check("rst_ch_addr_ok",  32'(ch_addr_ok),  32'(0));
    check("rst_pending_cnt", 32'(pending_cnt), 32'(0));
    check("rst_err",         32'(err),         32'(0));
    @(posedge clk); #1;
    resetn = 1'b1;

    // Both channels requesting, always accepted: priority / alternation.
    for (int i = 0; i < 4; i++) begin
      raise(0); raise(1);
      mem_data_ok = (i > 0);
      mem_rdata   = DW'($urandom);
      cycle();
    end
    req_r = '0; mem_data_ok = 1'b1;
    while (q_ids.size() > 0) cycle();
    mem_data_ok = 1'b0;

    // Grant lock: channel 1 waits, channel 0 arrives later and must not steal it.
    mem_addr_ok = 1'b0;
    raise(1); cycle();
    raise(0); cycle();
    cycle();
    mem_addr_ok = 1'b1;
    cycle();
    cycle();
    mem_data_ok = 1'b1;
    while (q_ids.size() > 0) cycle();
    mem_data_ok = 1'b0;

    // Ordering: issue ids 1,0,1,0 to fill the FIFO.
    raise(1); cycle();
    raise(0); cycle();
    raise(1); cycle();
    raise(0); cycle();

    // Full with a same-cycle response, then in-order responses A..D.
    raise(0); raise(1);
    mem_data_ok = 1'b1;
    mem_rdata = 32'hA; cycle();
    mem_addr_ok = 1'b0;
    mem_rdata = 32'hB; cycle();
    mem_rdata = 32'hC; cycle();
    mem_rdata = 32'hD; cycle();

    // Response with nothing outstanding: err sets and sticks.
    mem_rdata = 32'hE; cycle();
    mem_data_ok = 1'b0;
    cycle();
    mem_addr_ok = 1'b1;
    cycle();
    cycle();

    // Asynchronous reset with requests outstanding.
    raise(0); apply();
    #2 resetn = 1'b0;
    #1;
    check("arst_pending_cnt", 32'(pending_cnt), 32'(0));
    check("arst_err",         32'(err),         32'(0));
    check("arst_mem_req",     32'(mem_req),     32'(0));
    check("arst_ch_addr_ok",  32'(ch_addr_ok),  32'(0));
    model_reset();
    @(posedge clk); #1;
    resetn = 1'b1;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom % 2 == 0) raise(c);
      mem_addr_ok = ($urandom % 4) != 0;
      mem_data_ok = ($urandom % 3) == 0;
      mem_rdata   = DW'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Parametrised N-to-1 arbiter for sram-like memory requests (req/addr_ok/data_ok split handshake). It merges the CPU's memory request channels (instruction fetch, data access, later others) onto one shared downstream memory port. It tracks up to DEPTH outstanding requests and returns each response to the channel that issued it, in issue order. It sits between the pipeline stages and the AXI bridge, replacing fixed-latency direct SRAM ports.

## Interface
Parameters:
- NCH, 2, number of request channels (>=2); channel 0 is instruction fetch.
- DEPTH, 4, maximum outstanding (accepted, unanswered) requests (>=1).
- AW, 32, address width.
- DW, 32, data width (multiple of 8).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- resetn  in  1  reset, asynchronous and active-low.
- ch_req  in  NCH  per-channel request valid.
- ch_wr  in  NCH  per-channel write flag (1 = write).
- ch_size  in  2*NCH  per-channel size: 0 = byte, 1 = half, 2 = word.
- ch_wstrb  in  (DW/8)*NCH  per-channel byte strobes.
- ch_addr  in  AW*NCH  per-channel address.
- ch_wdata  in  DW*NCH  per-channel write data.
- ch_addr_ok  out  NCH  per-channel request accepted.
- ch_data_ok  out  NCH  per-channel response (read data valid or write done).
- ch_rdata  out  DW  read data, broadcast to all channels.
- mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/1/2/DW/8/AW/DW  downstream request.
- mem_addr_ok  in  1  downstream request accepted.
- mem_data_ok  in  1  downstream response.
- mem_rdata  in  DW  downstream read data.
- pending_cnt  out  clog2(DEPTH+1)  outstanding request count.
- err  out  1  sticky protocol error.

## Operation
- Grant selection:
  - Without a lock, the arbiter grants one requesting channel per the arbitration policy (see Configuration).
  - mem_* carries the granted channel's payload.
  - mem_req = 1 when any channel requests and pending_cnt < DEPTH.
- Grant lock:
  - When mem_req = 1 and mem_addr_ok = 0, the grant locks to that channel.
  - The lock releases on acceptance (mem_req & mem_addr_ok).
  - A higher-priority request never changes the payload that is waiting for acceptance.
- Acceptance:
  - ch_addr_ok[g] = mem_req & mem_addr_ok, where g is the granted channel.
  - The accepted channel's id is pushed into the id FIFO and pending_cnt increments.
- Response:
  - When mem_data_ok = 1 and the FIFO is non-empty, the arbiter pops the head id h and drives ch_data_ok[h] = 1.
  - ch_rdata = mem_rdata in every cycle.
- Full: when pending_cnt == DEPTH, mem_req is forced to 0 even if mem_data_ok pops in the same cycle (no bypass). Requests resume the next cycle.
- Empty: mem_data_ok with an empty FIFO asserts no ch_data_ok, sets err, and leaves pending_cnt at 0. This includes an acceptance and a data_ok in the same cycle on an empty FIFO; the downstream port never answers in its accept cycle.
- Simultaneous push and pop: pending_cnt unchanged; FIFO order preserved.
- Channel contract: a requesting channel holds req and its payload stable until it sees addr_ok.

## Timing
- ch_addr_ok, ch_data_ok, ch_rdata and mem_* are combinational from the current inputs and state; zero added latency.
- Grant lock, FIFO, pending_cnt, RR pointer and err are registered.
- Reset (asynchronous, any time, including mid-transfer):
  - FIFO emptied, pending_cnt = 0, lock cleared, RR pointer = NCH-1, err = 0.
  - All ch_addr_ok, ch_data_ok and mem_req are 0 while resetn = 0.
  - Responses still in flight downstream across a reset are the bridge's responsibility.
- err clears only on reset.
- Throughput: one acceptance and one response per cycle.

## Configuration
- ARB_RR_EN defined: round-robin arbitration.
  - Search starts at (last accepted channel + 1) mod NCH.
  - The pointer updates only on acceptance.
- ARB_RR_EN undefined: fixed priority, lowest index wins (channel 0 highest). No pointer register exists.

## Structure
- Package sram_like_pkg holds:
  - size encoding constants SIZE_B/SIZE_H/SIZE_W;
  - the clog2-based width constants ID_W = clog2(NCH) and CNT_W = clog2(DEPTH+1).
- Sub-module id_fifo: DEPTH entries x ID_W bits, with push/pop, full/empty and count. It supports simultaneous push and pop, and its pointers wrap modulo DEPTH.

## Test plan
- Fixed priority, no lock: ch_req = 2'b11, mem_addr_ok = 1 -> channel 0 accepted each cycle; ch_addr_ok = 2'b01.
- Round-robin (ARB_RR_EN): ch_req = 2'b11 for 4 cycles, mem_addr_ok = 1 -> grants 0,1,0,1.
- Grant lock: channel 1 alone, mem_addr_ok = 0 for 3 cycles, channel 0 raises req in cycle 2 -> mem_addr stays channel 1's until accepted; channel 0 is granted next.
- Ordering: DEPTH = 4; accept ids 1,0,1,0; data_ok 4 times with mem_rdata = 0xA..0xD -> ch_data_ok sequence 2'b10, 01, 10, 01 with matching data.
- Full: 4 accepted and unanswered -> mem_req = 0 and pending_cnt = 4 even with data_ok in the same cycle; next cycle mem_req = 1 and pending_cnt = 3.
- Error and reset: mem_data_ok with an empty FIFO -> err = 1 sticky, ch_data_ok = 0; resetn pulse with 2 pending -> pending_cnt = 0, err = 0 immediately.
